// File: rtl/rom_rd_arb_if.sv
// Request/response bundle shared by the two ROM requesters, the ROM and the
// arbiter. The master side is the environment (requesters plus ROM data);
// the slave side is the arbiter that grants, issues and returns data.
interface rom_rd_arb_if;
  logic       pri_mode;
  logic       req0_valid;
  logic [7:0] req0_addr;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_addr;
  logic       req1_ready;
  logic [7:0] rom_addr;
  logic       rom_rden;
  logic [7:0] rom_q;
  logic       rsp0_valid;
  logic       rsp1_valid;
  logic [7:0] rsp_data;

  modport master (
    output pri_mode, req0_valid, req0_addr, req1_valid, req1_addr, rom_q,
    input  req0_ready, req1_ready, rom_addr, rom_rden,
           rsp0_valid, rsp1_valid, rsp_data
  );

  modport slave (
    input  pri_mode, req0_valid, req0_addr, req1_valid, req1_addr, rom_q,
    output req0_ready, req1_ready, rom_addr, rom_rden,
           rsp0_valid, rsp1_valid, rsp_data
  );
endinterface

// File: rtl/rom_rd_arb.sv
// Two-port read arbiter in front of a single-port ROM with ROM_LAT cycles of
// read latency. One grant per cycle; a {vld,id} tag rides alongside each read
// so the returned word is steered to the requester that issued it.
module rom_rd_arb #(
  parameter int         ROM_LAT    = 2,
  parameter logic [3:0] STARVE_MAX = 4'd15
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  rom_rd_arb_if.slave  bus
);

  logic       last_grant;   // 1 = port 1 won last, so port 0 wins the next tie
  logic [3:0] starve_cnt;
  logic       both;
  logic       gnt0;
  logic       gnt1;
  logic       gnt_any;

  // Stage 0 is the cycle rom_rden is high; stage ROM_LAT is the cycle rom_q
  // carries that read's data.
  logic [ROM_LAT:0] vld_pipe;
  logic [ROM_LAT:0] id_pipe;

  // Grant decision; nothing is accepted while reset is asserted.
  always_comb begin
    both = bus.req0_valid && bus.req1_valid;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!sys_rst) begin
      if (both) begin
        if (bus.pri_mode) begin
          if (starve_cnt == STARVE_MAX) gnt1 = 1'b1;
          else                          gnt0 = 1'b1;
        end else begin
          if (last_grant) gnt0 = 1'b1;
          else            gnt1 = 1'b1;
        end
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  assign gnt_any        = gnt0 | gnt1;
  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rom_rden   = vld_pipe[0];

  // Round-robin history and port-1 starvation counter (counted in both modes).
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      last_grant <= 1'b1;
      starve_cnt <= 4'd0;
    end else begin
      if (gnt_any) last_grant <= gnt1;
      if (bus.req1_valid && !gnt1) begin
        if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= 4'd0;
      end
    end
  end

  // ROM address: load on grant, otherwise hold the last issued address.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)      bus.rom_addr <= 8'd0;
    else if (gnt1)    bus.rom_addr <= bus.req1_addr;
    else if (gnt0)    bus.rom_addr <= bus.req0_addr;
  end

  // Tag shift register; clearing it on reset drops every in-flight read.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[ROM_LAT-1:0], gnt_any};
      id_pipe  <= {id_pipe[ROM_LAT-1:0], gnt1};
    end
  end

  // Response capture at the tail of the tag pipe; data holds between responses.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp_data   <= 8'd0;
    end else begin
      bus.rsp0_valid <= vld_pipe[ROM_LAT] && !id_pipe[ROM_LAT];
      bus.rsp1_valid <= vld_pipe[ROM_LAT] &&  id_pipe[ROM_LAT];
      if (vld_pipe[ROM_LAT]) bus.rsp_data <= bus.rom_q;
    end
  end

endmodule
